// File: rtl/cla_nibble_seq_adder_if.sv
// Handshake/bus bundle for cla_nibble_seq_adder: operand request side and result side.
// CLA_NIBBLE_SEQ_ADDER_OVF_EN adds the ovf result signal.
interface cla_nibble_seq_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;
`ifdef CLA_NIBBLE_SEQ_ADDER_OVF_EN
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy, ovf
   );
`else
   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy
   );
`endif
endinterface

// File: rtl/cla_nibble_seq_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit carry-lookahead nibble per clock, LSB nibble first.
// Optional signed-overflow output enabled by CLA_NIBBLE_SEQ_ADDER_OVF_EN.
module cla_nibble_seq_adder #(
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   cla_nibble_seq_adder_if.slave    bus
);
   localparam int NIB = WIDTH / 4;
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   // Returns {c3, c4, z[3:0]}; every carry is a flat lookahead term, none rippled.
   function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
      logic [3:0] p;
      logic [3:0] g;
      logic       c1;
      logic       c2;
      logic       c3;
      logic       c4;
      logic [3:0] z;
      p  = x ^ y;
      g  = x & y;
      c1 = g[0] | (p[0] & c0);
      c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
      z  = p ^ {c3, c2, c1, c0};
      return {c3, c4, z};
   endfunction

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CW-1:0]     r_cnt;
   logic              r_carry;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [WIDTH-1:0]  r_sum;
   logic              r_cout;
   logic              r_in_ready;
   logic              r_out_valid;
   logic              r_busy;
   logic [3:0]        w_x;
   logic [3:0]        w_y;
   logic [5:0]        w_cla;
   logic              w_last;
`ifdef CLA_NIBBLE_SEQ_ADDER_OVF_EN
   logic              r_ovf;
`endif

   // Operand nibble selection and the per-cycle lookahead stage.
   always_comb begin
      w_x    = r_a[{r_cnt, 2'b00} +: 4];
      w_y    = r_b[{r_cnt, 2'b00} +: 4];
      w_cla  = cla4(w_x, w_y, r_carry);
      w_last = (r_cnt == LAST_NIB);
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (bus.in_valid) begin
               w_state_nxt = RUN;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         RUN: begin
            if (w_last) begin
               w_state_nxt = DONE;
            end else begin
               w_state_nxt = RUN;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = DONE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State register; handshake flags are registered from the next state so they track it exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= (w_state_nxt == IDLE);
         r_out_valid <= (w_state_nxt == DONE);
         r_busy      <= (w_state_nxt != IDLE);
      end
   end

   // Operand capture, nibble-wise sum update, carry chaining between cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= {WIDTH{1'b0}};
         r_b     <= {WIDTH{1'b0}};
         r_carry <= 1'b0;
         r_cnt   <= {CW{1'b0}};
         r_sum   <= {WIDTH{1'b0}};
         r_cout  <= 1'b0;
`ifdef CLA_NIBBLE_SEQ_ADDER_OVF_EN
         r_ovf   <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_a     <= bus.a;
                  r_b     <= bus.b;
                  r_carry <= bus.cin;
                  r_cnt   <= {CW{1'b0}};
               end
            end
            RUN: begin
               r_sum[{r_cnt, 2'b00} +: 4] <= w_cla[3:0];
               r_carry                    <= w_cla[4];
               if (w_last) begin
                  r_cout <= w_cla[4];
                  r_cnt  <= {CW{1'b0}};
`ifdef CLA_NIBBLE_SEQ_ADDER_OVF_EN
                  r_ovf  <= w_cla[4] ^ w_cla[5];
`endif
               end else begin
                  r_cnt  <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
               end
            end
            DONE: begin
               r_cnt <= {CW{1'b0}};
            end
            default: begin
               r_cnt <= {CW{1'b0}};
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.busy      = r_busy;
   assign bus.sum       = r_sum;
   assign bus.cout      = r_cout;
`ifdef CLA_NIBBLE_SEQ_ADDER_OVF_EN
   assign bus.ovf       = r_ovf;
`endif

endmodule
